aes_mixcolumn_seq: RTL and testbench
====================================

// Module: aes_mixcolumn_seq
// PURPOSE
//  Forward AES MixColumns (FIPS-197 5.1.3) on a full 128-bit state, one column per cycle.
//  Encryption-side counterpart of the combinational inverse MixColumns word function.
//  Sits in the encrypt round datapath between ShiftRows and AddRoundKey.
//  Uses valid/ready handshakes on both sides so the round controller can stall it.
// PARAMETERS
//  NB     4   columns per state; only 4 is legal (AES-128); sets counter range 0..NB-1
//  COL_W  32  bits per column; fixed at 32
// PORTS
//  clk        in   1    rising-edge clock
//  reset_n    in   1    synchronous reset, active low
//  s_valid    in   1    input state valid
//  s_ready    out  1    block can accept a state
//  s_state    in   128  input state; column c = [127-32c -: 32], byte b0 = column[31:24]
//  m_valid    out  1    result valid
//  m_ready    in   1    downstream accepts the result
//  m_state    out  128  MixColumns result; same packing as s_state
//  s_inv      in   1    only when AES_MIXCOL_INV_EN is defined: 1 = inverse MixColumns
// BEHAVIOUR
//  Reset: sampled on a clk edge with reset_n==0. Outputs: s_ready=0 during reset, 1 in the first
//   cycle after; m_valid=0; m_state=0. FSM->IDLE; column counter=0.
//  Reset mid-operation: abandons the state in flight; no output is produced for it.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE: s_ready=1. On s_valid: latch s_state into work reg, counter=0, -> BUSY.
//   BUSY: each cycle, replace column[cnt] with mix(column[cnt]) and increment cnt.
//    On the edge that processes cnt==NB-1: -> DONE, m_valid=1.
//   DONE: m_valid=1 and m_state stable until m_ready.
//    m_ready && !s_valid: -> IDLE.
//    m_ready && s_valid: s_ready=1. Latch the new state in the same edge and go -> BUSY
//     (back-to-back operation, no idle bubble).
//  s_ready = (state==IDLE) || (state==DONE && m_ready); combinational, no other path.
//  Latency: accept edge to m_valid = NB edges (4). Throughput: one state per 5 cycles.
//  Forward mix per column (b0..b3 -> r0..r3), GF(2^8) mod x^8+x^4+x^3+x+1:
//   r0=2b0^3b1^b2^b3  r1=b0^2b1^3b2^b3  r2=b0^b1^2b2^3b3  r3=3b0^b1^b2^2b3
//   xtime(x) = {x[6:0],1'b0} ^ (8'h1b & {8{x[7]}}); 3x = xtime(x)^x. All bytes are 8-bit; no carries.
//  s_valid while busy: ignored; s_ready=0 is backpressure, and the source must hold its data.
//  Counter wraps only via state transition; it never exceeds NB-1.
// CONFIGURATION
//  AES_MIXCOL_INV_EN defined:
//   - adds port s_inv, latched on the accept edge.
//   - s_inv=1 applies the inverse matrix {0e,0b,0d,09} circulant to each column.
//   - 9/11/13/14 multiples are built from xtime chains.
//   - latency and handshake are unchanged.
//  Not defined: port absent; the block is forward only. Inverse-only logic must be fully removed.
// STRUCTURE
//  Shared package/include aes_pkg: GF constant 8'h1b, functions xtime and gmul3
//   (plus gm09/gm11/gm13/gm14 under AES_MIXCOL_INV_EN), FSM state encodings.
//  Sub-module aes_mixcolumn_word: combinational 32-bit column mixer with an inv select tied
//   per the macro. Instantiated once and fed by a counter-indexed mux.
// TESTING
//  1. Column vectors (forward), one per state load:
//     db135345 -> 8e4da1bc; f20a225c -> 9fdc589d; 01010101 -> 01010101;
//     c6c6c6c6 -> c6c6c6c6; d4d4d4d5 -> d5d5d7d6; 2d26314c -> 4d7ebdf8.
//  2. Full state, m_ready=1:
//     s_state=db135345_f20a225c_01010101_c6c6c6c6 -> m_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
//     m_valid must rise exactly 4 edges after the accept edge.
//  3. Backpressure: hold m_ready=0 for 10 cycles.
//     -> m_valid=1 and m_state constant; s_ready=0 throughout.
//     Then pulse m_ready=1 -> m_valid=0 next cycle.
//  4. Back-to-back: s_valid held high, m_ready=1, two states.
//     -> second accept on the same edge the first result is taken; results 5 cycles apart.
//  5. Reset mid-op: reset_n=0 for 1 edge while in BUSY (cnt=2).
//     -> m_valid=0 and m_state=0; no stale result later; next state processes correctly.
//  6. With AES_MIXCOL_INV_EN: s_inv=1 on 8e4da1bc... -> db135345...
//     Forward then inverse on a random state returns the original (1000 random iterations).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and FSM encodings for the sequential MixColumns block.
// Inverse-only multipliers exist only when AES_MIXCOL_INV_EN is defined.
package aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (GF_POLY & {8{x[7]}});
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

`ifdef AES_MIXCOL_INV_EN
  // Inverse coefficients assembled from the x2/x4/x8 xtime chain.
  function automatic logic [7:0] gm09(input logic [7:0] x);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(x)));
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(x);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] x);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(x));
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction
`endif

endpackage

// File: rtl/aes_mixcolumn_word.sv
// Combinational MixColumns on one 32-bit column (b0 = col_in[31:24]).
// The inv select port and inverse matrix exist only when AES_MIXCOL_INV_EN is defined.
module aes_mixcolumn_word
  import aes_pkg::*;
(
`ifdef AES_MIXCOL_INV_EN
  input  logic        inv,
`endif
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] b0_s, b1_s, b2_s, b3_s;
  logic [31:0] fwd_s;
`ifdef AES_MIXCOL_INV_EN
  logic [31:0] rev_s;
`endif

  // Forward circulant {02,03,01,01}, plus the inverse {0e,0b,0d,09} when built in.
  always_comb begin
    b0_s = col_in[31:24];
    b1_s = col_in[23:16];
    b2_s = col_in[15:8];
    b3_s = col_in[7:0];
    fwd_s = {xtime(b0_s) ^ gmul3(b1_s) ^ b2_s ^ b3_s,
             b0_s ^ xtime(b1_s) ^ gmul3(b2_s) ^ b3_s,
             b0_s ^ b1_s ^ xtime(b2_s) ^ gmul3(b3_s),
             gmul3(b0_s) ^ b1_s ^ b2_s ^ xtime(b3_s)};
`ifdef AES_MIXCOL_INV_EN
    rev_s = {gm14(b0_s) ^ gm11(b1_s) ^ gm13(b2_s) ^ gm09(b3_s),
             gm09(b0_s) ^ gm14(b1_s) ^ gm11(b2_s) ^ gm13(b3_s),
             gm13(b0_s) ^ gm09(b1_s) ^ gm14(b2_s) ^ gm11(b3_s),
             gm11(b0_s) ^ gm13(b1_s) ^ gm09(b2_s) ^ gm14(b3_s)};
    if (inv) begin
      col_out = rev_s;
    end else begin
      col_out = fwd_s;
    end
`else
    col_out = fwd_s;
`endif
  end

endmodule

// File: rtl/aes_mixcolumn_seq.sv
// Sequential AES MixColumns over a 128-bit state, one column per cycle, valid/ready on both sides.
// Defining AES_MIXCOL_INV_EN adds the s_inv port selecting inverse MixColumns per state.
module aes_mixcolumn_seq
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int COL_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [NB*COL_W-1:0] s_state,
`ifdef AES_MIXCOL_INV_EN
  input  logic                s_inv,
`endif
  output logic                m_valid,
  input  logic                m_ready,
  output logic [NB*COL_W-1:0] m_state
);

  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [NB*COL_W-1:0] work_r;
  logic [COL_W-1:0]   col_sel_s;
  logic [COL_W-1:0]   col_mix_s;
  logic               accept_s;
`ifdef AES_MIXCOL_INV_EN
  logic               inv_r;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; DONE may hand straight over to BUSY on a same-edge accept.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_BUSY;
        else          state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_BUSY;
      end
      ST_DONE: begin
        if (m_ready && accept_s) state_nxt_s = ST_BUSY;
        else if (m_ready)        state_nxt_s = ST_IDLE;
        else                     state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs; s_ready is held low while reset is asserted.
  always_comb begin
    s_ready  = reset_n && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && m_ready));
    m_valid  = (state_r == ST_DONE);
    accept_s = s_valid && s_ready;
  end

  // Counter-indexed column select; column 0 sits in the top bits.
  always_comb begin
    col_sel_s = '0;
    for (int c = 0; c < NB; c++) begin
      if (cnt_r == CNT_W'(c)) col_sel_s = work_r[(NB-1-c)*COL_W +: COL_W];
      else                    col_sel_s = col_sel_s;
    end
  end

  aes_mixcolumn_word u_word (
`ifdef AES_MIXCOL_INV_EN
    .inv     (inv_r),
`endif
    .col_in  (col_sel_s),
    .col_out (col_mix_s)
  );

  // Work register: load on accept, otherwise overwrite one column per BUSY cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      work_r <= '0;
      cnt_r  <= '0;
`ifdef AES_MIXCOL_INV_EN
      inv_r  <= 1'b0;
`endif
    end else if (accept_s) begin
      work_r <= s_state;
      cnt_r  <= '0;
`ifdef AES_MIXCOL_INV_EN
      inv_r  <= s_inv;
`endif
    end else if (state_r == ST_BUSY) begin
      for (int c = 0; c < NB; c++) begin
        if (cnt_r == CNT_W'(c)) work_r[(NB-1-c)*COL_W +: COL_W] <= col_mix_s;
        else                    work_r[(NB-1-c)*COL_W +: COL_W] <= work_r[(NB-1-c)*COL_W +: COL_W];
      end
      if (cnt_r == CNT_LAST) cnt_r <= '0;
      else                   cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      work_r <= work_r;
      cnt_r  <= cnt_r;
    end
  end

  assign m_state = work_r;

endmodule

// File: tb/tb_aes_mixcolumn_seq.sv
// Self-checking bench for aes_mixcolumn_seq: directed vectors plus a cycle-level reference model.
// Inverse tests are enabled when AES_MIXCOL_INV_EN is defined.
module tb_aes_mixcolumn_seq;

`ifdef AES_MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_state = 128'd0;
  logic         s_inv = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [127:0] m_state;

  int checks = 0;
  int fails  = 0;

  aes_mixcolumn_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_state (s_state),
`ifdef AES_MIXCOL_INV_EN
    .s_inv   (s_inv),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_state (m_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [8:0] t;
    p = 8'd0;
    t = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t[7:0];
      t = t << 1;
      if (t[8]) t = t ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] col, input logic inv);
    logic [7:0] coef [4];
    logic [7:0] b [4];
    logic [7:0] r [4];
    if (inv) begin coef[0]=8'h0e; coef[1]=8'h0b; coef[2]=8'h0d; coef[3]=8'h09; end
    else     begin coef[0]=8'h02; coef[1]=8'h03; coef[2]=8'h01; coef[3]=8'h01; end
    for (int j = 0; j < 4; j++) b[j] = col[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'd0;
      for (int j = 0; j < 4; j++) r[i] = r[i] ^ gf_mul(b[j], coef[(j - i + 4) % 4]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] st, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = ref_col(st[127-32*c -: 32], inv);
    return o;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- cycle-level compare process ----------------
  typedef struct { logic [127:0] res; int acc; } item_t;
  item_t q[$];
  int    edges = 0;

  always @(negedge clk) begin
    bit exp_mv, exp_sr;
    item_t it;
    edges++;
    exp_mv = (q.size() > 0) && (edges >= q[0].acc + 4);
    exp_sr = reset_n && ((q.size() == 0) || (exp_mv && m_ready));
    chk(m_valid == exp_mv, "m_valid_cyc", {127'd0, m_valid}, {127'd0, exp_mv});
    chk(s_ready == exp_sr, "s_ready_cyc", {127'd0, s_ready}, {127'd0, exp_sr});
    if (exp_mv) chk(m_state == q[0].res, "m_state_cyc", m_state, q[0].res);
    if (!reset_n) begin
      q.delete();
    end else begin
      if (exp_mv && m_ready) void'(q.pop_front());
      if (s_valid && exp_sr) begin
        it.res = ref_state(s_state, s_inv & INV_EN);
        it.acc = edges + 1;
        q.push_back(it);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic xfer(input logic [127:0] st, input logic inv, input logic [127:0] exp, input string name);
    int n;
    int lat;
    s_state = st;
    s_inv   = inv;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!s_ready) begin
      chk(1'b0, {name, "_accept_timeout"}, 128'd0, 128'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk(lat == 4, {name, "_latency"}, 128'(lat), 128'd4);
    chk(m_state == exp, name, m_state, exp);
  endtask

  logic [31:0] vin  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
  logic [31:0] vout [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};

  localparam logic [127:0] FULL_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FULL_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  initial begin
    logic [127:0] held;
    logic [127:0] st_a, st_b, rnd;
    int t1, t2, n;
    bit ok;

    // Pin the model to the hand-computed column vectors.
    for (int i = 0; i < 6; i++)
      chk(ref_col(vin[i], 1'b0) == vout[i], "model_col", {96'd0, ref_col(vin[i], 1'b0)}, {96'd0, vout[i]});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk(s_ready == 1'b0, "reset_s_ready", {127'd0, s_ready}, 128'd0);
    chk(m_valid == 1'b0, "reset_m_valid", {127'd0, m_valid}, 128'd0);
    chk(m_state == 128'd0, "reset_m_state", m_state, 128'd0);
    reset_n = 1'b1;
    #1;
    chk(s_ready == 1'b1, "post_reset_s_ready", {127'd0, s_ready}, 128'd1);
    @(posedge clk); #1;

    // Column vectors, each replicated across the state.
    for (int i = 0; i < 6; i++)
      xfer({4{vin[i]}}, 1'b0, {4{vout[i]}}, "col_vec");

    // Full state.
    xfer(FULL_IN, 1'b0, FULL_OUT, "full_state");
    @(posedge clk); #1;

    // Backpressure: result held while m_ready is low.
    m_ready = 1'b0;
    xfer(FULL_IN, 1'b0, FULL_OUT, "bp_result");
    held = m_state;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!(m_valid && (m_state == held) && !s_ready)) ok = 1'b0;
    end
    chk(ok && (held == FULL_OUT), "bp_hold", held, FULL_OUT);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk(m_valid == 1'b0, "bp_release", {127'd0, m_valid}, 128'd0);

    // Back-to-back with s_valid held high.
    st_a = 128'h00112233_44556677_8899aabb_ccddeeff;
    st_b = 128'h2d26314c_d4d4d4d5_f20a225c_db135345;
    s_state = st_a;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_state = st_b;
    n = 0;
    while (!m_valid && n < 20) begin @(posedge clk); #1; n++; end
    t1 = edges;
    chk(m_state == ref_state(st_a, 1'b0), "b2b_first", m_state, ref_state(st_a, 1'b0));
    chk(s_ready == 1'b1, "b2b_ready", {127'd0, s_ready}, 128'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin @(posedge clk); #1; n++; end
    t2 = edges;
    chk(t2 - t1 == 5, "b2b_spacing", 128'(t2 - t1), 128'd5);
    chk(m_state == 128'h4d7ebdf8_d5d5d7d6_9fdc589d_8e4da1bc, "b2b_second", m_state,
        128'h4d7ebdf8_d5d5d7d6_9fdc589d_8e4da1bc);
    @(posedge clk); #1;

    // Reset in BUSY with cnt==2.
    s_state = FULL_IN;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk(m_valid == 1'b0, "midrst_m_valid", {127'd0, m_valid}, 128'd0);
    chk(m_state == 128'd0, "midrst_m_state", m_state, 128'd0);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (m_valid) ok = 1'b0;
    end
    chk(ok, "midrst_no_stale", {127'd0, m_valid}, 128'd0);
    xfer(FULL_IN, 1'b0, FULL_OUT, "midrst_next");

    // A few random states against the model.
    for (int i = 0; i < 20; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      xfer(rnd, 1'b0, ref_state(rnd, 1'b0), "rand_fwd");
    end

`ifdef AES_MIXCOL_INV_EN
    chk(ref_state(FULL_OUT, 1'b1) == FULL_IN, "model_inv", ref_state(FULL_OUT, 1'b1), FULL_IN);
    xfer(FULL_OUT, 1'b1, FULL_IN, "inv_vec");
    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      xfer(rnd, 1'b0, ref_state(rnd, 1'b0), "rt_fwd");
      xfer(ref_state(rnd, 1'b0), 1'b1, rnd, "rt_inv");
    end
`endif

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
